// File: rtl/glb_loader_if.sv
// Host-side command/stream bus and buffer write port of the global-buffer loader.
// The slave modport is the loader's view; the master modport is the host/buffer side.
interface glb_loader_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_COL     = 8,
    parameter int NUM_ROW     = 8,
    parameter int BUFFER_SIZE = 512,
    parameter int DATA_TYPES  = 3
);
    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int TW = $clog2(DATA_TYPES) + 1;
    localparam int WW = 2*DATA_WIDTH + $clog2(NUM_COL) + $clog2(NUM_ROW) + $clog2(DATA_TYPES) + 3;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [TW-1:0]           cmd_type;
    logic [AW-1:0]           cmd_base;
    logic [AW:0]             cmd_len;
    logic [7:0]              cmd_xwrap;
    logic                    s_valid;
    logic                    s_ready;
    logic [2*DATA_WIDTH-1:0] s_data;
    logic [AW-1:0]           addr_out;
    logic [WW-1:0]           data_out;
    logic                    load_ifmap;
    logic                    load_fltr;
    logic                    load_psum;

    modport master (
        output cmd_valid, cmd_type, cmd_base, cmd_len, cmd_xwrap, s_valid, s_data,
        input  cmd_ready, s_ready, addr_out, data_out, load_ifmap, load_fltr, load_psum
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_base, cmd_len, cmd_xwrap, s_valid, s_data,
        output cmd_ready, s_ready, addr_out, data_out, load_ifmap, load_fltr, load_psum
    );
endinterface

// File: rtl/glb_loader.sv
// Global-buffer loader: takes a load command and a raw word stream, tags each word with
// X/Y IDs and type, and drives the buffer write port with registered address, data and strobes.
module glb_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_COL     = 8,
    parameter int NUM_ROW     = 8,
    parameter int BUFFER_SIZE = 512,
    parameter int DATA_TYPES  = 3
) (
    input  logic          bus_clk,
    input  logic          rst,
    glb_loader_if.slave   bus,
    input  logic          ram_rst_busy,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int TW = $clog2(DATA_TYPES) + 1;
    localparam int XW = $clog2(NUM_COL) + 1;
    localparam int YW = $clog2(NUM_ROW) + 1;
    localparam int PW = 2*DATA_WIDTH;
    localparam int WW = PW + XW + YW + TW;

    localparam logic [TW-1:0] T_IFMAP   = TW'(1);
    localparam logic [TW-1:0] T_FLTR    = TW'(2);
    localparam logic [TW-1:0] T_PSUM    = TW'(3);
    localparam logic [TW-1:0] MAX_TYPE  = TW'(DATA_TYPES);
    localparam logic [AW:0]   MAX_LEN   = (AW+1)'(BUFFER_SIZE);
    localparam logic [7:0]    MAX_XWRAP = 8'(NUM_COL);
    localparam logic [YW-1:0] LAST_Y    = YW'(NUM_ROW - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   type_q, type_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW:0]     len_q, len_d;
    logic [7:0]      xwrap_q, xwrap_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            s_ready_q, s_ready_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [WW-1:0]   data_q, data_d;
    logic [2:0]      load_q, load_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            cmd_hs, s_hs, cmd_bad;

    // IFMAP/FLTR carry the element in the upper half of the data field; PSUM uses it whole.
    function automatic logic [WW-1:0] pack_word(input logic [PW-1:0] raw, input logic [TW-1:0] t,
                                                input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [PW-1:0] field;
        field = (t == T_PSUM) ? raw : {raw[DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
        return {field, x, y, t};
    endfunction

    assign cmd_hs  = bus.cmd_valid & cmd_ready_q & ~ram_rst_busy;
    assign s_hs    = bus.s_valid & s_ready_q & ~ram_rst_busy;
    assign cmd_bad = (bus.cmd_type == '0) || (bus.cmd_type > MAX_TYPE) ||
                     (bus.cmd_len == '0) || (bus.cmd_len > MAX_LEN) ||
                     (bus.cmd_xwrap == '0) || (bus.cmd_xwrap > MAX_XWRAP);

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        base_d  = base_q;
        len_d   = len_q;
        xwrap_d = xwrap_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        data_d  = data_q;
        load_d  = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            type_d  = '0;
            base_d  = '0;
            len_d   = '0;
            xwrap_d = '0;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_hs) begin
                        if (cmd_bad) begin
                            err_d = 1'b1;
                        end else begin
                            type_d  = bus.cmd_type;
                            base_d  = bus.cmd_base;
                            len_d   = bus.cmd_len;
                            xwrap_d = bus.cmd_xwrap;
                            cnt_d   = '0;
                            x_d     = '0;
                            y_d     = '0;
                            state_d = STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (s_hs) begin
                        addr_d = base_q + cnt_q[AW-1:0];
                        data_d = pack_word(bus.s_data, type_q, x_q, y_q);
                        load_d = {type_q == T_PSUM, type_q == T_FLTR, type_q == T_IFMAP};
                        cnt_d  = cnt_q + 1'b1;
                        if (8'(x_q) == xwrap_q - 8'd1) begin
                            x_d = '0;
                            y_d = (y_q == LAST_Y) ? '0 : y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        if (cnt_q == len_q - 1'b1) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        cmd_ready_d = (state_d == IDLE) & ~ram_rst_busy;
        s_ready_d   = (state_d == STREAM) & ~ram_rst_busy;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            type_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            xwrap_q     <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            cmd_ready_q <= 1'b0;
            s_ready_q   <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            load_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            base_q      <= base_d;
            len_q       <= len_d;
            xwrap_q     <= xwrap_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cmd_ready_q <= cmd_ready_d;
            s_ready_q   <= s_ready_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.s_ready    = s_ready_q;
    assign bus.addr_out   = addr_q;
    assign bus.data_out   = data_q;
    assign bus.load_ifmap = load_q[0];
    assign bus.load_fltr  = load_q[1];
    assign bus.load_psum  = load_q[2];
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
endmodule
